// File: rtl/iec_sd_arbiter.sv
// ---------------------------------------------------------------------------
// iec_sd_arbiter
// Shares the single hps_io SD block port between up to four IEC drive units.
// A round-robin arbiter grants one drive at a time, latches its LBA/count,
// issues one of sd_rd/sd_wr, and routes ack/buffer traffic to that drive only.
// Each transfer runs IDLE -> REQ -> XFER (ack high) -> DONE (ack low) -> IDLE.
//
// Ports:
//   clk_sys, reset        system clock, synchronous active-high reset
//   drv_lba/drv_blk_cnt   per-drive request address / block count (packed)
//   drv_rd/drv_wr         per-drive level requests, held until ack
//   drv_ack/drv_buff_wr   per-drive ack and buffer-write strobe (granted only)
//   drv_buff_din          per-drive write-buffer data (packed)
//   sd_lba/sd_blk_cnt     latched request towards the host
//   sd_rd/sd_wr           host request, at most one high
//   sd_ack/sd_buff_wr     host ack and buffer-write strobe
//   sd_buff_din           buffer data of the granted drive, 0 when idle
//   grant/busy/err        one-hot grant, non-idle flag, timeout abort pulse
//
// Optional feature: define IEC_SD_ARB_TIMEOUT_EN to enable a watchdog that
// aborts a transfer stuck in REQ/XFER for TIMEOUT_CYCLES clocks.
// ---------------------------------------------------------------------------
module iec_sd_arbiter #(
    parameter int          DRIVES         = 2,
    parameter bit          RR_EN_WR_FIRST = 1'b1,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd12000000,
    localparam int         NDR            = (DRIVES < 1) ? 1 : ((DRIVES > 4) ? 4 : DRIVES),
    localparam int         IW             = (NDR > 1) ? $clog2(NDR) : 1
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic [32*NDR-1:0]    drv_lba,
    input  logic [6*NDR-1:0]     drv_blk_cnt,
    input  logic [NDR-1:0]       drv_rd,
    input  logic [NDR-1:0]       drv_wr,
    output logic [NDR-1:0]       drv_ack,
    input  logic [8*NDR-1:0]     drv_buff_din,
    output logic [NDR-1:0]       drv_buff_wr,
    output logic [31:0]          sd_lba,
    output logic [5:0]           sd_blk_cnt,
    output logic                 sd_rd,
    output logic                 sd_wr,
    input  logic                 sd_ack,
    input  logic                 sd_buff_wr,
    output logic [7:0]           sd_buff_din,
    output logic [NDR-1:0]       grant,
    output logic                 busy,
    output logic                 err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t          r_state;
    logic [NDR-1:0]  r_grant;
    logic [IW-1:0]   r_rr;
    logic [31:0]     r_lba;
    logic [5:0]      r_blk;
    logic            r_sd_rd;
    logic            r_sd_wr;
    logic            r_is_wr;

    logic [NDR-1:0]  w_req;
    logic            w_pick_vld;
    logic [IW-1:0]   w_pick_idx;
    logic [31:0]     w_pick_lba;
    logic [5:0]      w_pick_blk;
    logic            w_pick_wr;
    logic [IW-1:0]   w_rr_next;
    logic            w_req_held;
    logic [7:0]      w_buff_din;

    assign w_req = drv_rd | drv_wr;

    // Round-robin pick: first pass covers indices >= rr, second pass wraps to the lowest index.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick_idx = '0;
        w_pick_lba = '0;
        w_pick_blk = '0;
        w_pick_wr  = 1'b0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < NDR; i++) begin
                if (!w_pick_vld && w_req[i] && (p == 1 || IW'(i) >= r_rr)) begin
                    w_pick_vld = 1'b1;
                    w_pick_idx = IW'(i);
                    w_pick_lba = drv_lba[32*i +: 32];
                    w_pick_blk = drv_blk_cnt[6*i +: 6];
                    w_pick_wr  = drv_wr[i] && (RR_EN_WR_FIRST || !drv_rd[i]);
                end
            end
        end
    end

    assign w_rr_next = (w_pick_idx == IW'(NDR - 1)) ? '0 : w_pick_idx + IW'(1);

    // The granted drive still holds the request that was actually issued.
    assign w_req_held = r_is_wr ? |(drv_wr & r_grant) : |(drv_rd & r_grant);

    // Buffer data mux; grant is zero when idle so the result is zero too.
    always_comb begin
        w_buff_din = '0;
        for (int i = 0; i < NDR; i++) begin
            if (r_grant[i]) begin
                w_buff_din = drv_buff_din[8*i +: 8];
            end
        end
    end

`ifdef IEC_SD_ARB_TIMEOUT_EN
    logic [23:0] r_cnt;
    logic        r_err;
`else
    logic        w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Arbiter state machine with registered host-side outputs.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_rr    <= '0;
            r_lba   <= '0;
            r_blk   <= '0;
            r_sd_rd <= 1'b0;
            r_sd_wr <= 1'b0;
            r_is_wr <= 1'b0;
`ifdef IEC_SD_ARB_TIMEOUT_EN
            r_cnt   <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
`ifdef IEC_SD_ARB_TIMEOUT_EN
            r_err <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_vld) begin
                        r_state <= ST_REQ;
                        r_grant <= NDR'(1) << w_pick_idx;
                        r_lba   <= w_pick_lba;
                        r_blk   <= w_pick_blk;
                        r_sd_wr <= w_pick_wr;
                        r_sd_rd <= !w_pick_wr;
                        r_is_wr <= w_pick_wr;
                        r_rr    <= w_rr_next;
`ifdef IEC_SD_ARB_TIMEOUT_EN
                        r_cnt   <= '0;
`endif
                    end
                end
                ST_REQ: begin
                    if (sd_ack) begin
                        // Host has latched the request; drop it for the data phase.
                        r_state <= ST_XFER;
                        r_sd_rd <= 1'b0;
                        r_sd_wr <= 1'b0;
                    end else if (!w_req_held) begin
                        r_state <= ST_IDLE;
                        r_sd_rd <= 1'b0;
                        r_sd_wr <= 1'b0;
                        r_grant <= '0;
                    end
                end
                ST_XFER: begin
                    if (!sd_ack) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Grant was held one cycle so the drive could see ack fall.
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
`ifdef IEC_SD_ARB_TIMEOUT_EN
            // Watchdog overrides the case above when it expires.
            if (r_state == ST_REQ || r_state == ST_XFER) begin
                if (r_cnt == TIMEOUT_CYCLES - 24'd1) begin
                    r_state <= ST_IDLE;
                    r_sd_rd <= 1'b0;
                    r_sd_wr <= 1'b0;
                    r_grant <= '0;
                    r_err   <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 24'd1;
                end
            end
`endif
        end
    end

    assign drv_ack     = {NDR{sd_ack}} & r_grant;
    assign drv_buff_wr = {NDR{sd_buff_wr}} & r_grant;
    assign sd_buff_din = w_buff_din;
    assign sd_lba      = r_lba;
    assign sd_blk_cnt  = r_blk;
    assign sd_rd       = r_sd_rd;
    assign sd_wr       = r_sd_wr;
    assign grant       = r_grant;
    assign busy        = (r_state != ST_IDLE);
`ifdef IEC_SD_ARB_TIMEOUT_EN
    assign err         = r_err;
`else
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_iec_sd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_iec_sd_arbiter
// Directed bench for iec_sd_arbiter with two drives. Expected grants are
// queued when requests are driven and checked when the arbiter issues them.
// ---------------------------------------------------------------------------
module tb_iec_sd_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] lba_a [2];
    logic [5:0]  blk_a [2];
    logic [7:0]  din_a [2];
    logic [63:0] drv_lba;
    logic [11:0] drv_blk_cnt;
    logic [15:0] drv_buff_din;
    logic [1:0]  drv_rd;
    logic [1:0]  drv_wr;
    logic [1:0]  drv_ack;
    logic [1:0]  drv_buff_wr;
    logic [31:0] sd_lba;
    logic [5:0]  sd_blk_cnt;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic        sd_buff_wr;
    logic [7:0]  sd_buff_din;
    logic [1:0]  grant;
    logic        busy;
    logic        err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          idx;
        bit          wr;
        logic [31:0] lba;
        logic [5:0]  blk;
    } exp_t;

    exp_t sb[$];

    assign drv_lba      = {lba_a[1], lba_a[0]};
    assign drv_blk_cnt  = {blk_a[1], blk_a[0]};
    assign drv_buff_din = {din_a[1], din_a[0]};

    always #5 clk = ~clk;

    iec_sd_arbiter #(
        .DRIVES         (2),
        .RR_EN_WR_FIRST (1'b1),
        .TIMEOUT_CYCLES (24'd100)
    ) dut (
        .clk_sys      (clk),
        .reset        (reset),
        .drv_lba      (drv_lba),
        .drv_blk_cnt  (drv_blk_cnt),
        .drv_rd       (drv_rd),
        .drv_wr       (drv_wr),
        .drv_ack      (drv_ack),
        .drv_buff_din (drv_buff_din),
        .drv_buff_wr  (drv_buff_wr),
        .sd_lba       (sd_lba),
        .sd_blk_cnt   (sd_blk_cnt),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_din  (sd_buff_din),
        .grant        (grant),
        .busy         (busy),
        .err          (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_req(input int idx, input bit wr);
        exp_t e;
        e.idx = idx;
        e.wr  = wr;
        e.lba = lba_a[idx];
        e.blk = blk_a[idx];
        sb.push_back(e);
    endtask

    // Wait (bounded) for the arbiter to issue a request, then check it against the queue head.
    task automatic wait_grant(output int idx, output bit wr, output int lat);
        int   n;
        exp_t e;
        n = 0;
        idx = 0;
        wr = 1'b0;
        while (!(sd_rd | sd_wr) && n < 20) begin
            @(negedge clk);
            n++;
        end
        lat = n;
        chk("grant_wait", 32'(n < 20), 32'd1);
        chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            idx = e.idx;
            wr  = e.wr;
            chk("grant_onehot", 32'(grant), 32'(2'b01 << e.idx));
            chk("sd_wr_issue", 32'(sd_wr), 32'(e.wr));
            chk("sd_rd_issue", 32'(sd_rd), 32'(!e.wr));
            chk("sd_lba", sd_lba, e.lba);
            chk("sd_blk_cnt", 32'(sd_blk_cnt), 32'(e.blk));
            chk("busy_req", 32'(busy), 32'd1);
        end
    endtask

    // Host holds ack for nack cycles while pulsing buffer writes; the drive drops its request on ack.
    task automatic xfer(input int idx, input bit wr, input int nack);
        logic [1:0] oh;
        oh = 2'b01 << idx;
        sd_ack = 1'b1;
        for (int c = 0; c < nack; c++) begin
            sd_buff_wr = c[0];
            @(negedge clk);
            chk("ack_route", 32'(drv_ack), 32'(oh));
            chk("buff_wr_route", 32'(drv_buff_wr), sd_buff_wr ? 32'(oh) : 32'd0);
            chk("buff_din_mux", 32'(sd_buff_din), 32'(din_a[idx]));
            chk("xfer_rdwr_clr", 32'({sd_rd, sd_wr}), 32'd0);
            if (c == 0) begin
                if (wr) drv_wr[idx] = 1'b0;
                else    drv_rd[idx] = 1'b0;
            end
        end
        sd_ack     = 1'b0;
        sd_buff_wr = 1'b0;
        @(negedge clk);
        chk("done_grant", 32'(grant), 32'(oh));
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_ack", 32'(drv_ack), 32'd0);
        @(negedge clk);
        chk("idle_grant", 32'(grant), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic serve(input int nack);
        int idx;
        bit wr;
        int lat;
        wait_grant(idx, wr, lat);
        xfer(idx, wr, nack);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench watchdog");
    end

    initial begin
        int idx;
        bit wr;
        int lat;

        reset      = 1'b1;
        drv_rd     = '0;
        drv_wr     = '0;
        sd_ack     = 1'b0;
        sd_buff_wr = 1'b0;
        lba_a[0]   = 32'h0;
        lba_a[1]   = 32'h0;
        blk_a[0]   = 6'd3;
        blk_a[1]   = 6'd17;
        din_a[0]   = 8'h3C;
        din_a[1]   = 8'hA5;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_sd_rd", 32'(sd_rd), 32'd0);
        chk("rst_sd_wr", 32'(sd_wr), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_lba", sd_lba, 32'd0);
        chk("rst_blk", 32'(sd_blk_cnt), 32'd0);
        chk("rst_buff_din", 32'(sd_buff_din), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Stray ack while idle reaches no drive
        sd_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("stray_ack", 32'(drv_ack), 32'd0);
        chk("stray_busy", 32'(busy), 32'd0);
        sd_ack = 1'b0;
        @(negedge clk);

        // Single read on drive 0, one-cycle issue latency, 5-cycle ack
        lba_a[0] = 32'h123;
        push_req(0, 1'b0);
        drv_rd[0] = 1'b1;
        wait_grant(idx, wr, lat);
        chk("single_latency", 32'(lat), 32'd1);
        xfer(idx, wr, 5);

        // Cancel before ack: request dropped in REQ returns to idle
        lba_a[0] = 32'h456;
        push_req(0, 1'b0);
        drv_rd[0] = 1'b1;
        wait_grant(idx, wr, lat);
        drv_rd[0] = 1'b0;
        @(negedge clk);
        chk("cancel_sd_rd", 32'(sd_rd), 32'd0);
        chk("cancel_grant", 32'(grant), 32'd0);
        chk("cancel_busy", 32'(busy), 32'd0);

        // Pointer stayed advanced past drive 0: drive 1 wins the tie
        lba_a[0] = 32'h1000;
        lba_a[1] = 32'h2000;
        push_req(1, 1'b0);
        push_req(0, 1'b0);
        drv_rd = 2'b11;
        serve(2);
        serve(2);

        // Reset during XFER drops everything and clears the pointer
        lba_a[0] = 32'h789;
        push_req(0, 1'b0);
        drv_rd[0] = 1'b1;
        wait_grant(idx, wr, lat);
        sd_ack = 1'b1;
        @(negedge clk);
        chk("xfer_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rstx_sd_rd", 32'(sd_rd), 32'd0);
        chk("rstx_grant", 32'(grant), 32'd0);
        chk("rstx_busy", 32'(busy), 32'd0);
        chk("rstx_ack", 32'(drv_ack), 32'd0);
        chk("rstx_lba", sd_lba, 32'd0);
        reset  = 1'b0;
        sd_ack = 1'b0;

        // Contention after reset: order 0,1,0,1 with requests re-raised
        lba_a[0] = 32'hA000;
        lba_a[1] = 32'hB000;
        push_req(0, 1'b0);
        push_req(1, 1'b0);
        drv_rd = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_grant(idx, wr, lat);
            xfer(idx, wr, 3);
            if (k < 2) begin
                drv_rd[idx] = 1'b1;
                push_req(idx, 1'b0);
            end
        end

        // Drive 1 requests rd and wr together: write first, then read
        lba_a[1] = 32'h55;
        push_req(1, 1'b1);
        push_req(1, 1'b0);
        drv_rd[1] = 1'b1;
        drv_wr[1] = 1'b1;
        serve(4);
        serve(4);

`ifdef IEC_SD_ARB_TIMEOUT_EN
        // Watchdog: ack never arrives, abort 100 cycles after REQ entry
        begin
            int n;
            lba_a[0] = 32'hDEAD;
            push_req(0, 1'b0);
            drv_rd[0] = 1'b1;
            wait_grant(idx, wr, lat);
            n = 0;
            while (!err && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("to_cycle", 32'(n), 32'd100);
            chk("to_sd_rd", 32'(sd_rd), 32'd0);
            chk("to_grant", 32'(grant), 32'd0);
            chk("to_ack", 32'(drv_ack), 32'd0);
            drv_rd[0] = 1'b0;
            @(negedge clk);
            chk("to_err_pulse", 32'(err), 32'd0);
        end
`endif

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
